// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit carry chain is split into STAGES
// registered segments, with skew registers for pending operand bits and deskew for finished sums.
module pipelined_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_in_valid,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    output logic [WIDTH-1:0] io_out_s,
    output logic             io_out_c,
    output logic             io_out_ovf
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    // Subtraction is a + ~b + ~borrow, so the carry chain itself is mode-agnostic.
    assign w_bx = io_in_sub ? ~io_in_b : io_in_b;
    assign w_c0 = io_in_sub ? ~io_in_cin : io_in_cin;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO   = gi * SEG;
            localparam int HI   = ((gi + 1) * SEG > WIDTH) ? WIDTH - 1 : (gi + 1) * SEG - 1;
            localparam int SW   = HI - LO + 1;
            localparam bit LAST = (gi == STAGES - 1);

            logic [WIDTH-1:LO] w_a_in;
            logic [WIDTH-1:LO] w_bx_in;
            logic              w_c_in;
            logic              w_v_in;
            logic [SW:0]       w_seg;
            logic [HI:0]       w_s_next;
            logic [HI:0]       r_s;
            logic              r_c;
            logic              r_v;

            if (gi == 0) begin : g_src
                assign w_a_in   = io_in_a;
                assign w_bx_in  = w_bx;
                assign w_c_in   = w_c0;
                assign w_v_in   = io_in_valid;
                assign w_s_next = w_seg[SW-1:0];
            end else begin : g_src
                assign w_a_in   = g_stage[gi-1].g_skew.r_a_hi;
                assign w_bx_in  = g_stage[gi-1].g_skew.r_bx_hi;
                assign w_c_in   = g_stage[gi-1].r_c;
                assign w_v_in   = g_stage[gi-1].r_v;
                assign w_s_next = {w_seg[SW-1:0], g_stage[gi-1].r_s};
            end

            assign w_seg = {1'b0, w_a_in[HI:LO]} + {1'b0, w_bx_in[HI:LO]} + {{SW{1'b0}}, w_c_in};

            if (!LAST) begin : g_skew
                logic [WIDTH-1:HI+1] r_a_hi;
                logic [WIDTH-1:HI+1] r_bx_hi;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_a_hi  <= '0;
                        r_bx_hi <= '0;
                        r_s     <= '0;
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                    end else if (io_en) begin
                        r_a_hi  <= w_a_in[WIDTH-1:HI+1];
                        r_bx_hi <= w_bx_in[WIDTH-1:HI+1];
                        r_s     <= w_s_next;
                        r_c     <= w_seg[SW];
                        r_v     <= w_v_in;
                    end
                end
            end else begin : g_final
                logic r_ovf;
                logic w_c_msb;

                // Sum MSB = a ^ bx ^ carry-in, so the carry into the MSB falls out of the segment sum.
                assign w_c_msb = w_a_in[HI] ^ w_bx_in[HI] ^ w_seg[SW-1];

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_s   <= '0;
                        r_c   <= 1'b0;
                        r_ovf <= 1'b0;
                        r_v   <= 1'b0;
                    end else if (io_en) begin
                        r_v <= w_v_in;
                        if (w_v_in) begin
                            r_s   <= w_s_next;
                            r_c   <= w_seg[SW];
                            r_ovf <= w_seg[SW] ^ w_c_msb;
                        end
                    end
                end
            end
        end
    endgenerate

    assign io_out_valid = g_stage[STAGES-1].r_v;
    assign io_out_s     = g_stage[STAGES-1].r_s;
    assign io_out_c     = g_stage[STAGES-1].r_c;
    assign io_out_ovf   = g_stage[STAGES-1].g_final.r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three instances (64/4, 11/3, 11/1) against an arithmetic model
// that treats the pipeline as a queue of beats, each due after its depth in enabled edges.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
    } res_t;

    typedef struct {
        logic        v;
        logic [63:0] s;
        logic        c;
        logic        ovf;
        int          due;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  vld;
    logic [2:0]  cin;
    logic [2:0]  sub;
    logic [63:0] a [3];
    logic [63:0] b [3];
    logic [2:0]  ov;
    logic [2:0]  oc;
    logic [2:0]  oo;
    logic [63:0] os0;
    logic [10:0] os1;
    logic [10:0] os2;
    logic [63:0] obs_s [3];

    logic        exp_v [3];
    logic        exp_c [3];
    logic        exp_o [3];
    logic [63:0] exp_s [3];
    beat_t       mq [3][$];
    int          en_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u_dut0 (
        .clock(clk), .reset(rst), .io_en(en), .io_in_valid(vld[0]),
        .io_in_a(a[0]), .io_in_b(b[0]), .io_in_cin(cin[0]), .io_in_sub(sub[0]),
        .io_out_valid(ov[0]), .io_out_s(os0), .io_out_c(oc[0]), .io_out_ovf(oo[0])
    );

    pipelined_add_sub #(.WIDTH(11), .STAGES(3)) u_dut1 (
        .clock(clk), .reset(rst), .io_en(en), .io_in_valid(vld[1]),
        .io_in_a(a[1][10:0]), .io_in_b(b[1][10:0]), .io_in_cin(cin[1]), .io_in_sub(sub[1]),
        .io_out_valid(ov[1]), .io_out_s(os1), .io_out_c(oc[1]), .io_out_ovf(oo[1])
    );

    pipelined_add_sub #(.WIDTH(11), .STAGES(1)) u_dut2 (
        .clock(clk), .reset(rst), .io_en(en), .io_in_valid(vld[2]),
        .io_in_a(a[2][10:0]), .io_in_b(b[2][10:0]), .io_in_cin(cin[2]), .io_in_sub(sub[2]),
        .io_out_valid(ov[2]), .io_out_s(os2), .io_out_c(oc[2]), .io_out_ovf(oo[2])
    );

    assign obs_s[0] = os0;
    assign obs_s[1] = {53'd0, os1};
    assign obs_s[2] = {53'd0, os2};

    function automatic int wid(int j);
        return (j == 0) ? 64 : 11;
    endfunction

    function automatic int dep(int j);
        return (j == 0) ? 4 : ((j == 1) ? 3 : 1);
    endfunction

    // Plain integer arithmetic: unsigned result decides carry/borrow, signed result decides overflow.
    function automatic res_t ref_calc(int w, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
        logic signed [66:0] full, half, mask, ux, uy, sx, sy, cc, tu, ts, m;
        res_t r;
        full = 67'sd1 <<< w;
        half = 67'sd1 <<< (w - 1);
        mask = full - 67'sd1;
        ux   = $signed({3'b000, x}) & mask;
        uy   = $signed({3'b000, y}) & mask;
        sx   = (ux ^ half) - half;
        sy   = (uy ^ half) - half;
        cc   = ci ? 67'sd1 : 67'sd0;
        if (sb) begin
            tu  = ux - uy - cc;
            ts  = sx - sy - cc;
            r.c = (tu >= 67'sd0);
        end else begin
            tu  = ux + uy + cc;
            ts  = sx + sy + cc;
            r.c = (tu >= full);
        end
        m     = tu & mask;
        r.s   = m[63:0];
        r.ovf = (ts >= half) || (ts < -half);
        return r;
    endfunction

    task automatic model_step();
        beat_t e;
        res_t  r;
        if (rst) begin
            en_cnt = 0;
            for (int j = 0; j < 3; j++) begin
                mq[j].delete();
                exp_v[j] = 1'b0;
                exp_s[j] = '0;
                exp_c[j] = 1'b0;
                exp_o[j] = 1'b0;
            end
        end else if (en) begin
            en_cnt = en_cnt + 1;
            for (int j = 0; j < 3; j++) begin
                r     = ref_calc(wid(j), a[j], b[j], cin[j], sub[j]);
                e.v   = vld[j];
                e.s   = r.s;
                e.c   = r.c;
                e.ovf = r.ovf;
                e.due = en_cnt + dep(j) - 1;
                mq[j].push_back(e);
                exp_v[j] = 1'b0;
                if (mq[j].size() > 0 && mq[j][0].due == en_cnt) begin
                    e = mq[j].pop_front();
                    exp_v[j] = e.v;
                    if (e.v) begin
                        exp_s[j] = e.s;
                        exp_c[j] = e.c;
                        exp_o[j] = e.ovf;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive0(logic v, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
        vld[0] = v;
        a[0]   = x;
        b[0]   = y;
        cin[0] = ci;
        sub[0] = sb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        vld = 3'b111;
        tick();
        tick();
        vld = 3'b000;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ov[j] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid dut%0d got %b want 0", j, ov[j]);
            end
            checks++;
            if (obs_s[j] !== 64'd0) begin
                errors++;
                $display("FAIL reset_s dut%0d got %h want 0", j, obs_s[j]);
            end
            checks++;
            if (oc[j] !== 1'b0 || oo[j] !== 1'b0) begin
                errors++;
                $display("FAIL reset_c_ovf dut%0d got c=%b ovf=%b want 0 0", j, oc[j], oo[j]);
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] va [5];
        logic [63:0] vb [5];
        logic [63:0] vs [5];
        logic [4:0]  vci, vsb, vc, vo;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vs[0] = 64'd0;
        va[1] = 64'd5;                   vb[1] = 64'd7; vs[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        va[2] = 64'd7;                   vb[2] = 64'd5; vs[2] = 64'd1;
        va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vs[3] = 64'h8000_0000_0000_0000;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vs[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        vci = 5'b00100;
        vsb = 5'b10110;
        vc  = 5'b10101;
        vo  = 5'b11000;
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, va[i], vb[i], vci[i], vsb[i]);
            tick();
            drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            repeat (3) tick();
            checks++;
            if (ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_valid got %b want 1", i, ov[0]);
            end
            checks++;
            if (obs_s[0] !== vs[i] || oc[0] !== vc[i] || oo[0] !== vo[i]) begin
                errors++;
                $display("FAIL dir%0d_result got s=%h c=%b ovf=%b want s=%h c=%b ovf=%b",
                         i, obs_s[0], oc[0], oo[0], vs[i], vc[i], vo[i]);
            end
            tick();
            checks++;
            if (ov[0] !== 1'b0 || obs_s[0] !== vs[i]) begin
                errors++;
                $display("FAIL dir%0d_hold got v=%b s=%h want v=0 s=%h", i, ov[0], obs_s[0], vs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ws [3];
        logic [2:0]  wc;
        ws[0] = 64'd0;
        ws[1] = 64'd0;
        ws[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        wc    = 3'b001;
        rst = 1'b0;
        en  = 1'b1;
        drive0(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 64'd0, 64'd1, 1'b0, 1'b1);
        tick();
        drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov[0] !== 1'b1 || obs_s[0] !== ws[i] || oc[0] !== wc[i] || oo[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b s=%h c=%b ovf=%b want v=1 s=%h c=%b ovf=0",
                         i, ov[0], obs_s[0], oc[0], oo[0], ws[i], wc[i]);
            end
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || obs_s[0] !== ws[2]) begin
            errors++;
            $display("FAIL b2b_drain got v=%b s=%h want v=0 s=%h", ov[0], obs_s[0], ws[2]);
        end
    endtask

    task automatic test_stall();
        logic [63:0] x, y, hs;
        logic        hc;
        res_t        r;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        r = ref_calc(64, x, y, 1'b1, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        drive0(1'b1, x, y, 1'b1, 1'b0);
        tick();
        drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        tick();
        hs = obs_s[0];
        hc = oc[0];
        en = 1'b0;
        drive0(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov[0] !== 1'b0 || obs_s[0] !== hs || oc[0] !== hc) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b s=%h c=%b want v=0 s=%h c=%b",
                         i, ov[0], obs_s[0], oc[0], hs, hc);
            end
        end
        drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_early got v=%b want 0", ov[0]);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b1 || obs_s[0] !== r.s || oc[0] !== r.c || oo[0] !== r.ovf) begin
            errors++;
            $display("FAIL stall_result got v=%b s=%h c=%b ovf=%b want v=1 s=%h c=%b ovf=%b",
                     ov[0], obs_s[0], oc[0], oo[0], r.s, r.c, r.ovf);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || obs_s[0] !== r.s) begin
            errors++;
            $display("FAIL stall_once got v=%b s=%h want v=0 s=%h", ov[0], obs_s[0], r.s);
        end
    endtask

    task automatic test_corners_11();
        logic [63:0] cv [6];
        cv[0] = 64'h000; cv[1] = 64'h001; cv[2] = 64'h3FF;
        cv[3] = 64'h400; cv[4] = 64'h7FF; cv[5] = 64'h555;
        rst = 1'b0;
        en  = 1'b1;
        vld[0] = 1'b0;
        for (int m = 0; m < 148; m++) begin
            if (m < 144) begin
                for (int j = 1; j < 3; j++) begin
                    vld[j] = 1'b1;
                    a[j]   = cv[m % 6];
                    b[j]   = cv[(m / 6) % 6];
                    cin[j] = m[5];
                    sub[j] = m[6] ^ m[7];
                end
            end else begin
                vld[2:1] = 2'b00;
            end
            tick();
            for (int j = 1; j < 3; j++) begin
                checks++;
                if (ov[j] !== exp_v[j] || obs_s[j] !== exp_s[j] || oc[j] !== exp_c[j] || oo[j] !== exp_o[j]) begin
                    errors++;
                    $display("FAIL corner11 dut%0d step%0d got v=%b s=%h c=%b ovf=%b want v=%b s=%h c=%b ovf=%b",
                             j, m, ov[j], obs_s[j], oc[j], oo[j], exp_v[j], exp_s[j], exp_c[j], exp_o[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] x;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 3; j++) begin
                vld[j] = ($urandom_range(0, 3) != 0);
                x = {$urandom, $urandom};
                case ($urandom_range(0, 7))
                    0: x = '1;
                    1: x = '0;
                    2: x = 64'h8000_0000_0000_0000 | (x & 64'h400);
                    default: ;
                endcase
                a[j]   = x;
                b[j]   = ($urandom_range(0, 5) == 0) ? 64'd1 : {$urandom, $urandom};
                cin[j] = $urandom_range(0, 1) != 0;
                sub[j] = $urandom_range(0, 1) != 0;
            end
            tick();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (ov[j] !== exp_v[j]) begin
                    errors++;
                    $display("FAIL rand_valid dut%0d cyc%0d got %b want %b", j, cyc, ov[j], exp_v[j]);
                end
                checks++;
                if (obs_s[j] !== exp_s[j] || oc[j] !== exp_c[j] || oo[j] !== exp_o[j]) begin
                    errors++;
                    $display("FAIL rand_result dut%0d cyc%0d got s=%h c=%b ovf=%b want s=%h c=%b ovf=%b",
                             j, cyc, obs_s[j], oc[j], oo[j], exp_s[j], exp_c[j], exp_o[j]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld = 3'b111;
            for (int j = 0; j < 3; j++) begin
                a[j]   = {$urandom, $urandom} | 64'h1;
                b[j]   = {$urandom, $urandom};
                cin[j] = 1'b1;
                sub[j] = 1'b0;
            end
            tick();
        end
        rst = 1'b1;
        en  = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ov[j] !== 1'b0 || obs_s[j] !== 64'd0 || oc[j] !== 1'b0 || oo[j] !== 1'b0) begin
                errors++;
                $display("FAIL inflight_reset dut%0d got v=%b s=%h c=%b ovf=%b want all 0",
                         j, ov[j], obs_s[j], oc[j], oo[j]);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        vld = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (ov[j] !== 1'b0 || obs_s[j] !== 64'd0) begin
                    errors++;
                    $display("FAIL inflight_drain dut%0d cyc%0d got v=%b s=%h want v=0 s=0",
                             j, i, ov[j], obs_s[j]);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        vld    = 3'b000;
        cin    = 3'b000;
        sub    = 3'b000;
        en_cnt = 0;
        for (int j = 0; j < 3; j++) begin
            a[j]     = '0;
            b[j]     = '0;
            exp_v[j] = 1'b0;
            exp_s[j] = '0;
            exp_c[j] = 1'b0;
            exp_o[j] = 1'b0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_corners_11();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
